// File: rtl/lsu_mem_ctrl.sv
// Load/store unit bridging EX/MEM to a req/ack data bus: lane steering, load extension, error flags.
// Define LSU_PERF_CNT_EN to add load/store/stall performance counters.
//
// state | meaning
// IDLE  | waiting for ex_valid; legal aligned ops are accepted, bad ops pulse err
// REQ   | mem_req held with stable address/data until mem_ack or timeout
// DONE  | result (or timeout error) presented for one cycle, pipeline released

module lsu_mem_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_we,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] dm_rd,
    output logic        dm_rd_valid,
    output logic        err,
    output logic [1:0]  err_code
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0] perf_loads,
    output logic [31:0] perf_stores,
    output logic [31:0] perf_stall
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         wstrb_q, wstrb_d;
    logic [31:0]        rd_q, rd_d;
    logic               rd_valid_q, rd_valid_d;
    logic               err_q, err_d;
    logic [1:0]         err_code_q, err_code_d;

    logic               op_legal;
    logic               op_misal;
    logic [31:0]        st_wdata;
    logic [3:0]         st_wstrb;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [31:0]        ld_ext;

    always_comb begin
        if (ex_we) begin
            op_legal = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010);
        end else begin
            op_legal = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010) ||
                       (ex_funct3 == 3'b100) || (ex_funct3 == 3'b101);
        end
        // funct3[1:0] encodes access size for every legal op: 00 byte, 01 half, 10 word
        op_misal = ((ex_funct3[1:0] == 2'b01) && ex_addr[0]) ||
                   ((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00));
    end

    always_comb begin
        st_wdata = ex_wdata;
        st_wstrb = 4'b1111;
        case (ex_funct3[1:0])
            2'b00: begin
                st_wdata = {4{ex_wdata[7:0]}};
                st_wstrb = 4'b0001 << ex_addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{ex_wdata[15:0]}};
                st_wstrb = ex_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
        if (!ex_we) begin
            st_wstrb = 4'b0000;
        end
    end

    always_comb begin
        ld_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'h000000, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'h0000, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rd_d       = rd_q;
        rd_valid_d = 1'b0;
        err_d      = 1'b0;
        err_code_d = 2'b00;
        stall      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ex_valid) begin
                    if (!op_legal) begin
                        err_d      = 1'b1;
                        err_code_d = 2'b10;
                    end else if (op_misal) begin
                        err_d      = 1'b1;
                        err_code_d = 2'b01;
                    end else begin
                        stall    = 1'b1;
                        we_d     = ex_we;
                        funct3_d = ex_funct3;
                        addr_d   = ex_addr;
                        wdata_d  = st_wdata;
                        wstrb_d  = st_wstrb;
                        cnt_d    = '0;
                        state_d  = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                // a late ack in the final timeout cycle still completes the access
                if (mem_ack) begin
                    if (!we_q) begin
                        rd_d       = ld_ext;
                        rd_valid_d = 1'b1;
                    end
                    state_d = ST_DONE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    err_d      = 1'b1;
                    err_code_d = 2'b11;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'b0000;
            rd_q       <= 32'h0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rd_q       <= rd_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign mem_req     = (state_q == ST_REQ);
    assign mem_we      = we_q;
    assign mem_addr    = {addr_q[31:2], 2'b00};
    assign mem_wdata   = wdata_q;
    assign mem_wstrb   = wstrb_q;
    assign dm_rd       = rd_q;
    assign dm_rd_valid = rd_valid_q;
    assign err         = err_q;
    assign err_code    = err_code_q;

`ifdef LSU_PERF_CNT_EN
    logic [31:0] perf_loads_q, perf_loads_d;
    logic [31:0] perf_stores_q, perf_stores_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_loads_d  = perf_loads_q;
        perf_stores_d = perf_stores_q;
        perf_stall_d  = perf_stall_q;
        if ((state_q == ST_REQ) && mem_ack) begin
            if (we_q) begin
                perf_stores_d = perf_stores_q + 32'd1;
            end else begin
                perf_loads_d = perf_loads_q + 32'd1;
            end
        end
        if (stall) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_loads_q  <= 32'h0;
            perf_stores_q <= 32'h0;
            perf_stall_q  <= 32'h0;
        end else begin
            perf_loads_q  <= perf_loads_d;
            perf_stores_q <= perf_stores_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_loads  = perf_loads_q;
    assign perf_stores = perf_stores_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed plan cases plus randomized ops against a behavioural model.
// A second instance with TIMEOUT=4 exercises the bus timeout and the ack-wins boundary.

module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_valid2;
    logic        ex_we;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata;
    logic        mem_ack, mem_ack2;
    logic [31:0] mem_rdata;

    logic        stall, mem_req, mem_we, dm_rd_valid, err;
    logic [31:0] mem_addr, mem_wdata, dm_rd;
    logic [3:0]  mem_wstrb;
    logic [1:0]  err_code;

    logic        stall2, mem_req2, mem_we2, dm_rd_valid2, err2;
    logic [31:0] mem_addr2, mem_wdata2, dm_rd2;
    logic [3:0]  mem_wstrb2;
    logic [1:0]  err_code2;

`ifdef LSU_PERF_CNT_EN
    logic [31:0] perf_loads, perf_stores, perf_stall;
    logic [31:0] perf_loads2, perf_stores2, perf_stall2;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_rd;
    int          m_loads, m_stores, m_stall;

    always #5 clk = ~clk;

    lsu_mem_ctrl u_dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_we(ex_we), .ex_funct3(ex_funct3),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .stall(stall), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .dm_rd(dm_rd), .dm_rd_valid(dm_rd_valid),
        .err(err), .err_code(err_code)
`ifdef LSU_PERF_CNT_EN
        , .perf_loads(perf_loads), .perf_stores(perf_stores), .perf_stall(perf_stall)
`endif
    );

    lsu_mem_ctrl #(.TIMEOUT(4), .CNT_W(8)) u_dut_to (
        .clk(clk), .rst(rst), .ex_valid(ex_valid2), .ex_we(ex_we), .ex_funct3(ex_funct3),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .stall(stall2), .mem_req(mem_req2),
        .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_wstrb(mem_wstrb2),
        .mem_ack(mem_ack2), .mem_rdata(mem_rdata), .dm_rd(dm_rd2), .dm_rd_valid(dm_rd_valid2),
        .err(err2), .err_code(err_code2)
`ifdef LSU_PERF_CNT_EN
        , .perf_loads(perf_loads2), .perf_stores(perf_stores2), .perf_stall(perf_stall2)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // 0 = accepted, 1 = misaligned, 2 = illegal funct3
    function automatic int classify(input logic we, input logic [2:0] f3, input logic [31:0] a);
        int size;
        bit legal;
        if (we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        if (!legal) return 2;
        size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd2) ? 4 : 2;
        if ((int'(a[1:0]) % size) != 0) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] v;
        case (f3)
            3'd0, 3'd4: begin
                v = (w >> (8 * a[1:0])) & 32'h0000_00FF;
                if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end
            3'd1, 3'd5: begin
                v = (w >> (16 * a[1])) & 32'h0000_FFFF;
                if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] strb_model(input logic we, input logic [2:0] f3, input logic [31:0] a);
        if (!we) return 32'h0;
        case (f3)
            3'd0:    return 32'd1 << a[1:0];
            3'd1:    return 32'd3 << a[1:0];
            default: return 32'hF;
        endcase
    endfunction

    function automatic logic [31:0] wdata_model(input logic [2:0] f3, input logic [31:0] wd);
        case (f3)
            3'd0:    return (wd & 32'hFF) * 32'h0101_0101;
            3'd1:    return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    // One op on the main instance; d = REQ cycle in which mem_ack is returned (1 = immediate)
    task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rword, input int d);
        int cls;
        int stall_seen;
        cls = classify(we, f3, a);
        @(negedge clk);
        ex_valid = 1'b1; ex_we = we; ex_funct3 = f3; ex_addr = a; ex_wdata = wd;
        mem_ack = 1'b0; mem_rdata = $urandom;
        #1;
        if (cls != 0) begin
            check_val("bad_op_stall", 32'(stall), 32'd0);
            check_val("bad_op_req", 32'(mem_req), 32'd0);
            @(negedge clk);
            ex_valid = 1'b0;
            #1;
            check_val("err_pulse", 32'(err), 32'd1);
            check_val("err_code", 32'(err_code), (cls == 1) ? 32'd1 : 32'd2);
            check_val("err_no_req", 32'(mem_req), 32'd0);
            check_val("err_no_rdv", 32'(dm_rd_valid), 32'd0);
            @(negedge clk);
            #1;
            check_val("err_clear", {29'd0, err, err_code}, 32'd0);
            return;
        end
        check_val("accept_stall", 32'(stall), 32'd1);
        check_val("accept_no_req", 32'(mem_req), 32'd0);
        stall_seen = 1;
        for (int k = 1; k <= d; k++) begin
            @(negedge clk);
            mem_ack   = (k == d);
            mem_rdata = (k == d) ? rword : $urandom;
            #1;
            check_val("req_high", 32'(mem_req), 32'd1);
            check_val("req_addr", mem_addr, a & 32'hFFFF_FFFC);
            check_val("req_we", 32'(mem_we), 32'(we));
            check_val("req_wstrb", 32'(mem_wstrb), strb_model(we, f3, a));
            if (we) check_val("req_wdata", mem_wdata, wdata_model(f3, wd));
            if (stall) stall_seen++;
        end
        @(negedge clk);
        ex_valid = 1'b0;
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        #1;
        check_val("stall_cycles", 32'(stall_seen), 32'(d + 1));
        check_val("done_stall", 32'(stall), 32'd0);
        check_val("done_req", 32'(mem_req), 32'd0);
        check_val("done_rdv", 32'(dm_rd_valid), we ? 32'd0 : 32'd1);
        check_val("done_err", 32'(err), 32'd0);
        if (!we) begin
            m_rd = load_model(f3, a, rword);
            m_loads++;
        end else begin
            m_stores++;
        end
        m_stall += d + 1;
        check_val("dm_rd", dm_rd, m_rd);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ex_valid = 1'b0;
            ex_we = 1'($urandom_range(0, 1));
            ex_funct3 = 3'($urandom_range(0, 7));
            ex_addr = $urandom;
            mem_ack = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            #1;
            check_val("idle_quiet", {28'd0, stall, mem_req, dm_rd_valid, err}, 32'd0);
            check_val("idle_rd_hold", dm_rd, m_rd);
        end
        @(negedge clk);
        mem_ack = 1'b0;
    endtask

    // Timeout instance: ack_at = 0 withholds ack, otherwise ack in that REQ cycle
    task automatic timeout_op(input int ack_at, input logic [31:0] rword);
        int req_cycles;
        bit left_req;
        @(negedge clk);
        ex_valid = 1'b0; ex_valid2 = 1'b1; ex_we = 1'b0; ex_funct3 = 3'd2; ex_addr = 32'h0000_0040;
        mem_ack2 = 1'b0;
        #1;
        check_val("to_accept_stall", 32'(stall2), 32'd1);
        req_cycles = 0;
        left_req = 1'b0;
        for (int k = 1; k <= 20 && !left_req; k++) begin
            @(negedge clk);
            mem_ack2  = (k == ack_at);
            mem_rdata = (k == ack_at) ? rword : $urandom;
            #1;
            if (mem_req2) begin
                req_cycles++;
            end else begin
                left_req = 1'b1;
                ex_valid2 = 1'b0;
                mem_ack2 = 1'b0;
            end
        end
        ex_valid2 = 1'b0;
        if (ack_at == 0) begin
            check_val("to_req_cycles", 32'(req_cycles), 32'd4);
            check_val("to_err", 32'(err2), 32'd1);
            check_val("to_err_code", 32'(err_code2), 32'd3);
            check_val("to_no_rdv", 32'(dm_rd_valid2), 32'd0);
        end else begin
            check_val("ackwin_req_cycles", 32'(req_cycles), 32'(ack_at));
            check_val("ackwin_no_err", 32'(err2), 32'd0);
            check_val("ackwin_rdv", 32'(dm_rd_valid2), 32'd1);
            check_val("ackwin_rd", dm_rd2, rword);
        end
        check_val("to_done_stall", 32'(stall2), 32'd0);
        @(negedge clk);
        #1;
        check_val("to_back_idle", {29'd0, err2, mem_req2, stall2}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ex_valid = 1'b0; ex_valid2 = 1'b0; ex_we = 1'b0; ex_funct3 = 3'd0;
        ex_addr = 32'h0; ex_wdata = 32'h0; mem_ack = 1'b0; mem_ack2 = 1'b0; mem_rdata = 32'h0;
        m_rd = 32'h0; m_loads = 0; m_stores = 0; m_stall = 0;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_ctrl", {27'd0, stall, mem_req, mem_we, dm_rd_valid, err}, 32'd0);
        check_val("rst_addr", mem_addr, 32'h0);
        check_val("rst_wdata", mem_wdata, 32'h0);
        check_val("rst_wstrb", 32'(mem_wstrb), 32'd0);
        check_val("rst_dm_rd", dm_rd, 32'h0);
        check_val("rst_err_code", 32'(err_code), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op(1'b0, 3'd0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1);
        do_op(1'b0, 3'd5, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 5);
        do_op(1'b1, 3'd0, 32'h0000_3001, 32'h0000_00AB, 32'h0, 2);
        do_op(1'b0, 3'd2, 32'h0000_4002, 32'h0, 32'h0, 1);
        do_op(1'b0, 3'd3, 32'h0000_5000, 32'h0, 32'h0, 1);
        do_op(1'b1, 3'd4, 32'h0000_5004, 32'h1234_5678, 32'h0, 1);
        do_op(1'b1, 3'd1, 32'h0000_6002, 32'h1234_CAFE, 32'h0, 3);
        do_op(1'b1, 3'd2, 32'h0000_7000, 32'hDEAD_BEEF, 32'h0, 1);
        idle_cycles(3);

        timeout_op(0, 32'h0);
        timeout_op(4, 32'h5A5A_1234);

        // reset while a load is outstanding
        @(negedge clk);
        ex_valid = 1'b1; ex_we = 1'b0; ex_funct3 = 3'd2; ex_addr = 32'h0000_0020; mem_ack = 1'b0;
        #1;
        check_val("rstreq_accept", 32'(stall), 32'd1);
        @(negedge clk);
        #1;
        check_val("rstreq_req", 32'(mem_req), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; ex_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        #1;
        m_rd = 32'h0; m_loads = 0; m_stores = 0; m_stall = 0;
        check_val("rstreq_req_drop", 32'(mem_req), 32'd0);
        check_val("rstreq_quiet", {29'd0, stall, dm_rd_valid, err}, 32'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        check_val("rstreq_stray_ack", {30'd0, dm_rd_valid, err}, 32'd0);
        do_op(1'b0, 3'd2, 32'h0000_0010, 32'h0, 32'h1357_9BDF, 1);

        for (int i = 0; i < 150; i++) begin
            logic        r_we;
            logic [2:0]  r_f3;
            logic [31:0] r_addr;
            r_we   = 1'($urandom_range(0, 1));
            r_f3   = 3'($urandom_range(0, 7));
            r_addr = $urandom;
            if ($urandom_range(0, 1) == 1) r_addr[1:0] = 2'b00;
            do_op(r_we, r_f3, r_addr, $urandom, $urandom, $urandom_range(1, 6));
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
        end

`ifdef LSU_PERF_CNT_EN
        check_val("perf_loads", perf_loads, 32'(m_loads));
        check_val("perf_stores", perf_stores, 32'(m_stores));
        check_val("perf_stall", perf_stall, 32'(m_stall));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit that sits between the EX/MEM stage and the data-memory bus.
- Produces the aligned, sign/zero-extended load data consumed as the memory-output source of the register-file write-data selection.
- Drives a req/ack memory bus with byte strobes, stalls the pipeline while an access is outstanding, and flags misaligned, illegal and timed-out accesses.

Parameters:
- TIMEOUT, 255, cycles to wait for mem_ack before aborting; 0 disables the timeout.
- CNT_W, 8, width of the timeout counter; must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  memory operation presented; held stable by the pipeline while stall=1.
- ex_we  in  1  1=store, 0=load.
- ex_funct3  in  3  RV32I load/store funct3.
- ex_addr  in  32  byte address.
- ex_wdata  in  32  store data from rs2.
- stall  out  1  freeze upstream stages.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write.
- mem_addr  out  32  word-aligned address, {ex_addr[31:2],2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_wstrb  out  4  byte strobes; 4'b0000 for loads.
- mem_ack  in  1  one-cycle completion pulse from memory.
- mem_rdata  in  32  read word, valid with mem_ack.
- dm_rd  out  32  extended load result.
- dm_rd_valid  out  1  one-cycle pulse; dm_rd is valid.
- err  out  1  one-cycle pulse on misaligned, illegal or timeout.
- err_code  out  2  01 misaligned, 10 illegal funct3, 11 timeout; 00 otherwise.

Behaviour:
- Reset values: state=IDLE; stall, mem_req, mem_we, dm_rd_valid and err are 0; mem_addr, mem_wdata, dm_rd and err_code are 0; mem_wstrb is 4'b0000; counter is 0.
- Legal funct3 for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal funct3 for stores: 000 SB, 001 SH, 010 SW.
- Any other funct3 is illegal.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
- IDLE state:
  - ex_valid with a legal, aligned op: latch op, addr and wdata; go to REQ next edge.
  - stall is combinationally 1 in this accept cycle.
  - ex_valid with a misaligned or illegal op: err=1 with err_code for one cycle at the next edge; no bus activity; stall=0; stay in IDLE.
- REQ state:
  - mem_req=1 with stable address, we, wdata and wstrb; stall=1.
  - Counter increments each cycle in REQ.
  - mem_ack=1: capture mem_rdata, go to DONE.
  - TIMEOUT!=0 and counter reaches TIMEOUT-1 without ack: drop mem_req, err=1 with err_code=11 for one cycle, go to DONE with dm_rd_valid=0.
  - If mem_ack arrives in that same cycle, the ack wins.
- DONE state:
  - stall=0. For loads, dm_rd_valid=1 and dm_rd holds the extended data.
  - Stores produce no dm_rd_valid.
  - Always return to IDLE next edge; ex_valid is ignored in DONE because the pipeline advances this cycle.
- Latency with immediate ack: accept at cycle N, mem_req at N+1, ack at N+1, DONE/result at N+2, next op accepted at N+3.
- Load extraction:
  - sh = addr[1:0]*8.
  - LB: sign-extend rdata[sh+:8].
  - LBU: zero-extend rdata[sh+:8].
  - LH and LHU use rdata[16*addr[1]+:16], sign- or zero-extended respectively.
  - LW returns rdata.
- Store lanes:
  - SB: wdata={4{b}}, wstrb=4'b0001<<addr[1:0].
  - SH: wdata={2{h}}, wstrb=addr[1]?1100:0011.
  - SW: wstrb=1111.
- dm_rd holds its last value outside DONE.
- mem_ack while in IDLE or DONE is ignored.
- rst asserted in any state: IDLE on the next edge and mem_req drops that edge; no dm_rd_valid or err pulse is generated for the aborted op.

Optional Feature:
- Macro LSU_PERF_CNT_EN.
- When defined, adds three outputs: perf_loads[31:0], perf_stores[31:0] and perf_stall[31:0].
  - perf_loads and perf_stores count completed (acked) loads and stores.
  - perf_stall counts cycles with stall=1.
  - All three clear on rst and wrap at 2^32.
- When undefined, these ports and registers are absent; all other behaviour is identical.

Test Plan:
- LB at addr 0x1003, mem_rdata=0x80FF_1234, immediate ack -> dm_rd=0xFFFF_FF80 with dm_rd_valid at N+2; mem_addr=0x1000.
- LHU at 0x2002, rdata=0xBEEF_0000, ack after 5 cycles -> stall=1 for 6 cycles, then dm_rd=0x0000_BEEF.
- SB at 0x3001 with wdata=0x0000_00AB -> mem_we=1, mem_wstrb=0010, mem_wdata=0xABAB_ABAB, no dm_rd_valid.
- LW at 0x4002 -> err=1 and err_code=01 for one cycle, mem_req stays 0, stall=0.
- funct3=011 load -> err_code=10. Separately, TIMEOUT=4 with ack withheld -> mem_req high 4 cycles, then err_code=11 and return to IDLE.
- rst asserted for one cycle in REQ -> mem_req=0 next edge; a later stray mem_ack produces no dm_rd_valid; a fresh LW at 0x10 completes normally.
